// File: rtl/mdu_alu.sv
// Execute-stage ALU with registered single-cycle ops and iterative MULT/MULTU/DIV/DIVU into HI/LO.
// Multiply is shift-add and divide is restoring, one bit per cycle, with sign fix-up on the last edge.
module mdu_alu #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] ALU_operand_1,
  input  logic [WIDTH-1:0] ALU_operand_2,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD  = 4'b0010,
                         OP_XOR = 4'b0011, OP_NOR = 4'b0100, OP_SUB  = 4'b0110,
                         OP_SLT = 4'b0111, OP_SLTU = 4'b1000,
                         OP_MULT = 4'b1010, OP_MULTU = 4'b1011,
                         OP_DIV  = 4'b1100, OP_DIVU  = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opd;
  logic                 neg_q, neg_r, dz;

  logic                 is_mul, is_div, sgn, a_neg, b_neg, b_zero, last_iter;
  logic [WIDTH-1:0]     a_mag, b_mag, alu_res;
  logic [WIDTH:0]       mul_sum, div_trial;
  logic                 div_ok;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, mul_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;

  assign zero      = (ALU_operand_1 == ALU_operand_2);
  assign is_mul    = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
  assign is_div    = (alucontrol == OP_DIV)  || (alucontrol == OP_DIVU);
  assign sgn       = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
  assign a_neg     = sgn & ALU_operand_1[WIDTH-1];
  assign b_neg     = sgn & ALU_operand_2[WIDTH-1];
  assign a_mag     = a_neg ? -ALU_operand_1 : ALU_operand_1;
  assign b_mag     = b_neg ? -ALU_operand_2 : ALU_operand_2;
  assign b_zero    = (ALU_operand_2 == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    case (alucontrol)
      OP_AND:  alu_res = ALU_operand_1 & ALU_operand_2;
      OP_OR:   alu_res = ALU_operand_1 | ALU_operand_2;
      OP_ADD:  alu_res = ALU_operand_1 + ALU_operand_2;
      OP_XOR:  alu_res = ALU_operand_1 ^ ALU_operand_2;
      OP_NOR:  alu_res = ~(ALU_operand_1 | ALU_operand_2);
      OP_SUB:  alu_res = ALU_operand_1 - ALU_operand_2;
      OP_SLT:  alu_res = WIDTH'($signed(ALU_operand_1) < $signed(ALU_operand_2));
      OP_SLTU: alu_res = WIDTH'(ALU_operand_1 < ALU_operand_2);
      default: alu_res = '0;
    endcase
  end

  // One iteration step of each engine; the remainder never exceeds 2*divisor so WIDTH+1 bits suffice.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opd};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1];
  assign div_nxt   = {div_rem, acc[WIDTH-2:0], div_ok};
  assign mul_fix   = neg_q ? -mul_nxt : mul_nxt;
  assign q_fix     = neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
  assign r_fix     = neg_r ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) state_nxt = is_mul ? S_MUL : (is_div ? S_DIV : S_DONE);
      end
      S_MUL: if (last_iter) state_nxt = S_DONE;
      S_DIV: if (dz || last_iter) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_MUL) || (state == S_DIV);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; acc <= '0; opd <= '0; neg_q <= 1'b0; neg_r <= 1'b0; dz <= 1'b0;
      aluout <= '0; hi <= '0; lo <= '0; div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          div_by_zero <= 1'b0;
          cnt         <= '0;
          if (is_mul) begin
            acc   <= {{WIDTH{1'b0}}, b_mag};
            opd   <= a_mag;
            neg_q <= a_neg ^ b_neg;
          end else if (is_div) begin
            // on divide-by-zero the raw dividend is parked in the remainder half for HI
            acc   <= {b_zero ? ALU_operand_1 : {WIDTH{1'b0}}, a_mag};
            opd   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz    <= b_zero;
          end else begin
            aluout <= alu_res;
          end
        end
        S_MUL: begin
          acc <= mul_nxt;
          cnt <= last_iter ? '0 : cnt + CNT_W'(1);
          if (last_iter) {hi, lo} <= mul_fix;
        end
        S_DIV: begin
          if (dz) begin
            lo          <= '1;
            hi          <= acc[2*WIDTH-1:WIDTH];
            div_by_zero <= 1'b1;
            dz          <= 1'b0;
          end else begin
            acc <= div_nxt;
            cnt <= last_iter ? '0 : cnt + CNT_W'(1);
            if (last_iter) begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_alu.sv
// Scoreboard bench for mdu_alu: expected results queued at start, compared at done.
module tb_mdu_alu;
  localparam int W = 32;
  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011,
                         NOR_ = 4'b0100, SUB = 4'b0110, SLT = 4'b0111, SLTU = 4'b1000,
                         MULT = 4'b1010, MULTU = 4'b1011, DIV = 4'b1100, DIVU = 4'b1101;

  logic clk = 0, rst_n = 0, start = 0;
  logic [3:0] alucontrol = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] aluout, hi, lo;
  logic zero, busy, done, div_by_zero;

  mdu_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alucontrol(alucontrol),
    .ALU_operand_1(a), .ALU_operand_2(b), .aluout(aluout), .zero(zero),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] alu, hi, lo;
    logic         dbz;
    int           lat, nbusy;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] m_alu = '0, m_hi = '0, m_lo = '0;
  logic m_dbz = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output exp_t e);
    longint sx, sy;
    logic [2*W-1:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m_dbz = 1'b0;
    e.lat = 1; e.nbusy = 0;
    case (op)
      AND_: m_alu = x & y;
      OR_:  m_alu = x | y;
      ADD:  m_alu = x + y;
      XOR_: m_alu = x ^ y;
      NOR_: m_alu = ~(x | y);
      SUB:  m_alu = x - y;
      SLT:  m_alu = (sx < sy) ? 1 : 0;
      SLTU: m_alu = (x < y) ? 1 : 0;
      MULT, MULTU: begin
        if (op == MULT) p = 64'(sx * sy);
        else            p = {32'b0, x} * {32'b0, y};
        {m_hi, m_lo} = p;
        e.lat = W + 1; e.nbusy = W;
      end
      DIV, DIVU: begin
        if (y == 0) begin
          m_lo = '1; m_hi = x; m_dbz = 1'b1;
          e.lat = 2; e.nbusy = 1;
        end else begin
          if (op == DIV) begin m_lo = W'(sx / sy); m_hi = W'(sx % sy); end
          else           begin m_lo = x / y;       m_hi = x % y;       end
          e.lat = W + 1; e.nbusy = W;
        end
      end
      default: m_alu = '0;
    endcase
    e.alu = m_alu; e.hi = m_hi; e.lo = m_lo; e.dbz = m_dbz;
  endtask

  // now=1 issues start in the current (DONE) cycle; poke=1 fires ignored starts mid-operation
  task automatic run(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                     input bit now = 0, input bit poke = 0);
    exp_t e, g;
    int cyc, nb;
    if (!now) @(negedge clk);
    alucontrol = op; a = x; b = y; start = 1;
    model(op, x, y, e);
    sb.push_back(e);
    @(negedge clk);
    start = 0; cyc = 1; nb = 0;
    while (!done && cyc < 200) begin
      if (busy) nb++;
      if (poke) begin
        chk("zero", zero, a == b);
        start = 0;
        if (cyc == 5)  begin start = 1; alucontrol = ADD; a = $urandom; b = $urandom; end
        if (cyc == 10) begin start = 1; alucontrol = SUB; b = a; end
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (!done) chk("timeout", 0, 1);
    g = sb.pop_front();
    chk("latency", cyc, g.lat);
    chk("busy_cycles", nb, g.nbusy);
    chk("aluout", aluout, g.alu);
    chk("hi", hi, g.hi);
    chk("lo", lo, g.lo);
    chk("div_by_zero", div_by_zero, g.dbz);
    if (poke) begin
      @(negedge clk);
      chk("done_once", done, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_aluout", aluout, 0); chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_dbz", div_by_zero, 0);
    rst_n = 1;

    run(ADD, 7, 5);
    run(SLT, 32'hFFFF_FFFF, 1);
    run(SLTU, 32'hFFFF_FFFF, 1);
    run(MULT, -32'sd3, 7);
    run(MULTU, 32'hFFFF_FFFF, 2);
    run(ADD, 32'hFFFF_FFFF, 1, 1);
    run(DIV, -32'sd7, 2);
    run(DIVU, 100, 7);
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(DIVU, 5, 0);
    run(ADD, 1, 1);
    run(DIV, -32'sd9, 0);
    run(SUB, 3, 5, 1);
    run(XOR_, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run(NOR_, 32'h00FF_0000, 32'h0000_00F0);
    run(AND_, 32'hDEAD_BEEF, 32'hFFFF_0000);
    run(OR_, 32'h1200_0000, 32'h0000_0034);
    run(4'b1111, 9, 9);
    run(MULT, 32'h1234_5678, -32'sd1000, 0, 1);
    run(MULT, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) begin
      run(MULT + 4'(i % 4), $urandom, (i == 5) ? 32'd3 : $urandom);
      run(DIV + 4'(i % 2), $urandom, $urandom_range(1, 1000) * ((i % 3 == 0) ? -1 : 1));
    end

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    alucontrol = DIV; a = -32'sd100; b = 7; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst_n = 0;
    #1;
    chk("arst_aluout", aluout, 0); chk("arst_hi", hi, 0); chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1;
    m_alu = '0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    run(ADD, 2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_alu.md
Name: mdu_alu

Overview:
- Sequential, parametrised successor to the single-cycle datapath ALU.
- Adds signed and unsigned multiply and divide into HI/LO registers (MIPS MULT/MULTU/DIV/DIVU), plus XOR, NOR and SLTU.
- Single-cycle ops are registered. Multiply and divide run iteratively with a start/busy/done handshake; the controller stalls the pipeline on busy.
- Sits in the datapath execute stage, in place of the old ALU.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE or DONE.
- alucontrol  input  4  operation select, sampled with start.
- ALU_operand_1  input  WIDTH  operand A (dividend / multiplicand).
- ALU_operand_2  input  WIDTH  operand B (divisor / multiplier).
- aluout  output  WIDTH  registered result of single-cycle ops.
- zero  output  1  combinational: (ALU_operand_1 == ALU_operand_2); independent of start and state.
- hi  output  WIDTH  mult: upper product; div: remainder.
- lo  output  WIDTH  mult: lower product; div: quotient.
- busy  output  1  high while state is MUL or DIV.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  registered flag; set by a div with B=0, cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; counter=0.
  - aluout, hi, lo, busy, done, div_by_zero all = 0.
  - An in-flight operation is aborted with no partial HI/LO writeback.
- Single-cycle opcodes:
  - 0010 add; 0110 sub (both wrap mod 2^WIDTH).
  - 0000 and; 0001 or; 0011 xor; 0100 nor.
  - 0111 slt, signed; 1000 sltu, unsigned (result 1 or 0, zero-extended).
- Multi-cycle opcodes: 1010 mult (signed), 1011 multu, 1100 div (signed), 1101 divu.
- Other opcodes: aluout=0, hi/lo unchanged, done pulses.
- States: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + start + single-cycle op: aluout registered at that edge; go to DONE.
  - IDLE/DONE + start + mult: latch magnitudes and result sign; counter=0; go to MUL.
  - IDLE/DONE + start + div: same latching; go to DIV.
  - DONE without start: return to IDLE.
  - start in MUL/DIV: ignored; no queuing; operands and opcode may change freely.
- MUL: shift-add, one multiplier bit per cycle.
- DIV: restoring division, one quotient bit per cycle.
- On the WIDTH-th iteration edge: sign correction applied, hi/lo written, go to DONE.
- done = (state==DONE), so it pulses for exactly one cycle per accepted start.
  - Back-to-back starts issued while in DONE give a new done pulse each time.
- Latency (start cycle = cycle 0):
  - single-cycle op: done in cycle 1.
  - mult/div: busy in cycles 1..WIDTH, done in cycle WIDTH+1.
- aluout holds its value across mult/div. hi/lo hold their value across single-cycle ops.
- Sign rules:
  - Signed product uses the full 2*WIDTH bits.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / -1: lo = MIN, hi = 0 (no trap).
- Divide by zero (div or divu, B==0):
  - Skip iteration: DIV lasts one cycle, done in cycle 2.
  - lo = all ones, hi = A, div_by_zero = 1.
- Counter counts 0..WIDTH-1 and never wraps mid-operation.

Test Plan:
- add 7+5 with start: aluout=12 and done=1 in cycle 1, busy never high; then slt 0xFFFFFFFF vs 1 gives aluout=1, sltu on the same operands gives 0.
- mult -3 * 7: busy for cycles 1..32, done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; multu 0xFFFFFFFF * 2 gives hi=1, lo=0xFFFFFFFE.
- div -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 100 / 7: lo=14, hi=2; div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu 5 / 0: done in cycle 2, div_by_zero=1, lo=0xFFFFFFFF, hi=5; the next add start clears div_by_zero.
- start pulsed with changing operands in cycles 5 and 10 of a mult: ignored, result unchanged, one done pulse only; zero tracks operand equality every cycle.
- rst_n dropped in cycle 10 of a div: all outputs 0 immediately (async); after release, a new add completes normally and hi/lo stay 0.
